detection_event_logger: RTL

Downstream consumer of the sequence-detector `detected` output. It timestamps every cycle in which the detector fires and tags each event with the active detector mode. Events are buffered in a small FIFO and handed to a slower sink over a valid/ready interface. The block also keeps saturating totals of hits and drops, so software can read detection statistics without losing event order.

---
 rtl/detect_pkg.sv | 20 ++
 rtl/detection_event_logger_if.sv | 14 +
 rtl/event_fifo.sv | 48 ++++
 rtl/detection_event_logger.sv | 76 +++++++
 4 files changed

// File: rtl/detect_pkg.sv
// Shared types for the sequence detector and its event logger:
// detector mode tags and the logged event record.
package detect_pkg;

    typedef enum logic [1:0] {
        MODE_MOORE_OV  = 2'b00,
        MODE_MOORE_NOV = 2'b01,
        MODE_MEALY_OV  = 2'b10,
        MODE_MEALY_NOV = 2'b11
    } mode_t;

    // Widest timestamp any logger instance may carry.
    localparam int MAX_TS_W = 32;

    typedef struct packed {
        logic [MAX_TS_W-1:0] ts;
        mode_t               mode;
    } event_t;

endpackage

// File: rtl/detection_event_logger_if.sv
// Valid/ready event stream from the logger to a slower sink.
interface detection_event_logger_if
    import detect_pkg::*;
#(
    parameter int TS_W = 16
);
    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W-1:0] evt_ts;
    mode_t           evt_mode;

    modport master (output evt_valid, evt_ts, evt_mode, input evt_ready);
    modport slave  (input evt_valid, evt_ts, evt_mode, output evt_ready);
endinterface

// File: rtl/event_fifo.sv
// Generic synchronous show-ahead FIFO; head is visible on dout whenever not empty.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;
    logic             init;

    assign init  = rst | flush;
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign rd_en = pop & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign wr_en = push & ~init & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (init) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

    assign dout = mem[rd_ptr_reg[AW-1:0]];
endmodule

// File: rtl/detection_event_logger.sv
// Timestamps detector hits, queues them for a slow sink and keeps
// saturating hit/drop statistics.
module detection_event_logger
    import detect_pkg::*;
#(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     hit,
    input  mode_t                    mode,
    detection_event_logger_if.master evt,
    output logic [CNT_W-1:0]         hit_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow
);
    localparam int EW = TS_W + 2;

    logic [TS_W-1:0]  ts_cnt_reg;
    logic [CNT_W-1:0] hit_count_reg;
    logic [CNT_W-1:0] drop_count_reg;
    logic             overflow_reg;
    logic             full;
    logic             empty;
    logic             pop;
    logic             drop;
    logic [EW-1:0]    head;

    assign pop  = ~empty & evt.evt_ready;
    assign drop = hit & full & ~pop;

    event_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (hit),
        .pop   (pop),
        .din   ({ts_cnt_reg, mode}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ts_cnt_reg     <= '0;
            hit_count_reg  <= '0;
            drop_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + TS_W'(1);
            if (hit && hit_count_reg != '1)
                hit_count_reg <= hit_count_reg + CNT_W'(1);
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_count_reg != '1)
                    drop_count_reg <= drop_count_reg + CNT_W'(1);
            end
        end
    end

    // Head fields read as zero while the queue is empty.
    assign evt.evt_valid = ~empty;
    assign evt.evt_ts    = empty ? '0 : head[EW-1:2];
    assign evt.evt_mode  = empty ? MODE_MOORE_OV : mode_t'(head[1:0]);

    assign hit_count  = hit_count_reg;
    assign drop_count = drop_count_reg;
    assign overflow   = overflow_reg;
endmodule
